ahb_lite_arbiter2: RTL

Two-master AHB-Lite arbiter that shares the single system AHB-Lite bus between master 0 (Cortex-M0 core) and master 1 (DMA or debug loader). It sits upstream of the address decoder and slave multiplexer. It multiplexes address/control and write data onto the shared bus and routes HREADY/HRESP/HRDATA back to the master that owns each phase. Each master has a one-entry address-phase holding register, so a master that loses arbitration is stalled transparently and never needs a grant signal.

---
 rtl/ahb_lite_arbiter2_if.sv | 45 ++++
 rtl/ahb_lite_arbiter2.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ahb_lite_arbiter2_if.sv
// Signal bundle for the two-master AHB-Lite arbiter: both master-side buses
// plus the shared system bus on the slave-multiplexer side.
interface ahb_lite_arbiter2_if;
    logic [31:0] HADDR_M0, HADDR_M1;
    logic [1:0]  HTRANS_M0, HTRANS_M1;
    logic        HWRITE_M0, HWRITE_M1;
    logic [2:0]  HSIZE_M0, HSIZE_M1;
    logic [2:0]  HBURST_M0, HBURST_M1;
    logic [3:0]  HPROT_M0, HPROT_M1;
    logic        HMASTLOCK_M0, HMASTLOCK_M1;
    logic [31:0] HWDATA_M0, HWDATA_M1;
    logic        HREADYOUT_M0, HREADYOUT_M1;
    logic        HRESP_M0, HRESP_M1;
    logic [31:0] HRDATA_M0, HRDATA_M1;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        HMASTER;

    modport slave (
        input  HADDR_M0, HADDR_M1, HTRANS_M0, HTRANS_M1, HWRITE_M0, HWRITE_M1,
               HSIZE_M0, HSIZE_M1, HBURST_M0, HBURST_M1, HPROT_M0, HPROT_M1,
               HMASTLOCK_M0, HMASTLOCK_M1, HWDATA_M0, HWDATA_M1,
               HREADY, HRESP, HRDATA,
        output HREADYOUT_M0, HREADYOUT_M1, HRESP_M0, HRESP_M1, HRDATA_M0, HRDATA_M1,
               HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA, HMASTER
    );

    modport master (
        output HADDR_M0, HADDR_M1, HTRANS_M0, HTRANS_M1, HWRITE_M0, HWRITE_M1,
               HSIZE_M0, HSIZE_M1, HBURST_M0, HBURST_M1, HPROT_M0, HPROT_M1,
               HMASTLOCK_M0, HMASTLOCK_M1, HWDATA_M0, HWDATA_M1,
               HREADY, HRESP, HRDATA,
        input  HREADYOUT_M0, HREADYOUT_M1, HRESP_M0, HRESP_M1, HRDATA_M0, HRDATA_M1,
               HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA, HMASTER
    );
endinterface

// File: rtl/ahb_lite_arbiter2.sv
// Two-master AHB-Lite arbiter: zero-latency address mux with per-master
// one-entry holding registers so a losing master is stalled transparently.
module ahb_lite_arbiter2 #(
    parameter int PRIORITY_MODE  = 1,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    ahb_lite_arbiter2_if.slave bus
);
    localparam logic       DEF_M        = (DEFAULT_MASTER != 0) ? 1'b1 : 1'b0;
    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic        lock;
    } addr_ctl_t;

    addr_ctl_t  live_s [2];
    addr_ctl_t  hold_r [2];
    addr_ctl_t  eff_s  [2];
    addr_ctl_t  bus_s;
    logic [1:0] hold_v_r;
    logic [1:0] hreadyout_s;
    logic [1:0] live_req_s;
    logic [1:0] req_s;
    logic       addr_owner_r;
    logic       data_owner_r;
    logic       data_v_r;
    logic       last_winner_r;
    logic       owner_lock_r;
    logic       keep_s;
    logic       winner_s;

    assign live_s[0] = {bus.HADDR_M0, bus.HTRANS_M0, bus.HWRITE_M0, bus.HSIZE_M0,
                        bus.HBURST_M0, bus.HPROT_M0, bus.HMASTLOCK_M0};
    assign live_s[1] = {bus.HADDR_M1, bus.HTRANS_M1, bus.HWRITE_M1, bus.HSIZE_M1,
                        bus.HBURST_M1, bus.HPROT_M1, bus.HMASTLOCK_M1};

    // Ready back to each master: stalled while its transfer is held or pending
    always_comb begin
        hreadyout_s = 2'b11;
        for (int i = 0; i < 2; i++) begin
            if (data_v_r && (data_owner_r == i[0])) begin
                hreadyout_s[i] = bus.HREADY;
            end else if (hold_v_r[i]) begin
                hreadyout_s[i] = 1'b0;
            end else begin
                hreadyout_s[i] = 1'b1;
            end
        end
    end

    // Live requests and effective (held or live) address phase per master
    always_comb begin
        live_req_s = 2'b00;
        for (int i = 0; i < 2; i++) begin
            live_req_s[i] = live_s[i].trans[1] & hreadyout_s[i];
            eff_s[i]      = hold_v_r[i] ? hold_r[i] : live_s[i];
        end
    end

    assign req_s  = hold_v_r | live_req_s;
    // trans[0] set means SEQ or BUSY: an unfinished burst is never split
    assign keep_s = owner_lock_r | eff_s[addr_owner_r].trans[0];

    // Address-phase winner
    always_comb begin
        winner_s = addr_owner_r;
        if (!bus.HREADY || keep_s) begin
            winner_s = addr_owner_r;
        end else if (req_s == 2'b11) begin
            winner_s = (PRIORITY_MODE != 0) ? ~last_winner_r : 1'b0;
        end else if (req_s[0]) begin
            winner_s = 1'b0;
        end else if (req_s[1]) begin
            winner_s = 1'b1;
        end else begin
            winner_s = DEF_M;
        end
    end

    assign bus_s = eff_s[winner_s];

    // Hold capture for losers or stalled bus; release on acceptance
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hold_v_r <= 2'b00;
            hold_r[0] <= '0;
            hold_r[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (bus.HREADY && (winner_s == i[0])) begin
                    hold_v_r[i] <= 1'b0;
                end else if (live_req_s[i] && !hold_v_r[i]) begin
                    hold_v_r[i] <= 1'b1;
                    hold_r[i]   <= live_s[i];
                end else begin
                    hold_v_r[i] <= hold_v_r[i];
                end
            end
        end
    end

    // Ownership, data-phase tracking, lock and round-robin history
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_owner_r  <= DEF_M;
            data_owner_r  <= DEF_M;
            data_v_r      <= 1'b0;
            last_winner_r <= 1'b1;
            owner_lock_r  <= 1'b0;
        end else begin
            addr_owner_r <= winner_s;
            if (bus.HREADY) begin
                data_v_r     <= (bus_s.trans != TRANS_IDLE);
                data_owner_r <= winner_s;
                owner_lock_r <= bus_s.lock;
                if (bus_s.trans == TRANS_NONSEQ) begin
                    last_winner_r <= winner_s;
                end
            end
        end
    end

    assign bus.HADDR        = bus_s.addr;
    assign bus.HTRANS       = HRESETn ? bus_s.trans : TRANS_IDLE;
    assign bus.HWRITE       = bus_s.write;
    assign bus.HSIZE        = bus_s.size;
    assign bus.HBURST       = bus_s.burst;
    assign bus.HPROT        = bus_s.prot;
    assign bus.HMASTLOCK    = HRESETn & bus_s.lock;
    assign bus.HWDATA       = data_owner_r ? bus.HWDATA_M1 : bus.HWDATA_M0;
    assign bus.HMASTER      = data_v_r ? data_owner_r : DEF_M;
    assign bus.HREADYOUT_M0 = hreadyout_s[0];
    assign bus.HREADYOUT_M1 = hreadyout_s[1];
    assign bus.HRESP_M0     = (data_v_r && !data_owner_r) ? bus.HRESP : 1'b0;
    assign bus.HRESP_M1     = (data_v_r && data_owner_r) ? bus.HRESP : 1'b0;
    assign bus.HRDATA_M0    = bus.HRDATA;
    assign bus.HRDATA_M1    = bus.HRDATA;
endmodule
